// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and next-PC select encoding for the fetch-stage program counter.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int OFFSET_W_DEF  = 6;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int RESET_PC_DEF  = 0;

    typedef logic [2:0] pc_sel_t;

    localparam pc_sel_t SEL_INC    = 3'd0;
    localparam pc_sel_t SEL_BRANCH = 3'd1;
    localparam pc_sel_t SEL_JUMP   = 3'd2;
    localparam pc_sel_t SEL_CALL   = 3'd3;
    localparam pc_sel_t SEL_RET    = 3'd4;
    localparam pc_sel_t SEL_HOLD   = 3'd5;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// and a pop while empty leaves the state untouched and reports no valid data.
module pc_sequencer_return_stack #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] pushData_i,
    output logic [DATA_W-1:0] topData_o,
    output logic              popValid_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  ptr_q, ptr_d, topIdx;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ptr_q is the next write slot; once full it also points at the oldest entry.
    assign topIdx     = ptr_q - PTR_W'(1);
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign popValid_o = !empty_o;
    assign topData_o  = mem_q[topIdx];

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full_o) begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d   = topIdx;
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[ptr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, absolute jump, sign-magnitude branch,
// call/return through a return-address stack, and stall.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int OFFSET_W  = OFFSET_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int RESET_PC  = RESET_PC_DEF
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                iStall,
    input  logic                iJump,
    input  logic                iCall,
    input  logic                iReturn,
    input  logic                iBranchTaken,
    input  logic [ADDR_W-1:0]   iTarget,
    input  logic [OFFSET_W-1:0] iOffset,
    output logic [ADDR_W-1:0]   oIP,
    output logic                oRasEmpty,
    output logic                oRasFull,
    output logic                oRasOverflow,
    output logic                oRasUnderflow
);

    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [ADDR_W-1:0] ipInc, magExt, branchPc, rasTop;
    logic              rasOverflow_q, rasOverflow_d;
    logic              rasUnderflow_q, rasUnderflow_d;
    logic              rasPush, rasPop, rasValid, rasEmpty, rasFull;
    pc_sel_t           sel;

    assign ipInc    = ip_q + ADDR_W'(1);
    assign magExt   = ADDR_W'(iOffset[OFFSET_W-2:0]);
    assign branchPc = iOffset[OFFSET_W-1] ? (ip_q - magExt) : (ip_q + magExt);

    // Only the highest-priority request wins; the rest are ignored this cycle.
    always_comb begin
        if (iStall) begin
            sel = SEL_HOLD;
        end else if (iReturn) begin
            sel = SEL_RET;
        end else if (iCall) begin
            sel = SEL_CALL;
        end else if (iJump) begin
            sel = SEL_JUMP;
        end else if (iBranchTaken) begin
            sel = SEL_BRANCH;
        end else begin
            sel = SEL_INC;
        end
    end

    always_comb begin
        ip_d           = ip_q;
        rasPush        = 1'b0;
        rasPop         = 1'b0;
        rasOverflow_d  = 1'b0;
        rasUnderflow_d = 1'b0;
        case (sel)
            SEL_INC:    ip_d = ipInc;
            SEL_BRANCH: ip_d = branchPc;
            SEL_JUMP:   ip_d = iTarget;
            SEL_CALL: begin
                ip_d          = iTarget;
                rasPush       = 1'b1;
                rasOverflow_d = rasFull;
            end
            SEL_RET: begin
                rasPop = 1'b1;
                if (rasValid) begin
                    ip_d = rasTop;
                end else begin
                    ip_d           = ipInc;
                    rasUnderflow_d = 1'b1;
                end
            end
            default:    ip_d = ip_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ip_q           <= ADDR_W'(RESET_PC);
            rasOverflow_q  <= 1'b0;
            rasUnderflow_q <= 1'b0;
        end else begin
            ip_q           <= ip_d;
            rasOverflow_q  <= rasOverflow_d;
            rasUnderflow_q <= rasUnderflow_d;
        end
    end

    pc_sequencer_return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .push_i     (rasPush),
        .pop_i      (rasPop),
        .pushData_i (ipInc),
        .topData_o  (rasTop),
        .popValid_o (rasValid),
        .empty_o    (rasEmpty),
        .full_o     (rasFull)
    );

    assign oIP           = ip_q;
    assign oRasEmpty     = rasEmpty;
    assign oRasFull      = rasFull;
    assign oRasOverflow  = rasOverflow_q;
    assign oRasUnderflow = rasUnderflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the PC and return stack.
module tb_pc_sequencer;

    localparam int AW    = 10;
    localparam int OW    = 6;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << AW;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          iStall, iJump, iCall, iReturn, iBranchTaken;
    logic [AW-1:0] iTarget;
    logic [OW-1:0] iOffset;
    logic [AW-1:0] oIP;
    logic          oRasEmpty, oRasFull, oRasOverflow, oRasUnderflow;

    int checks = 0;
    int errors = 0;

    int mIp;
    int ras[$];
    bit expOvf, expUnf;

    pc_sequencer #(
        .ADDR_W    (AW),
        .OFFSET_W  (OW),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .iStall        (iStall),
        .iJump         (iJump),
        .iCall         (iCall),
        .iReturn       (iReturn),
        .iBranchTaken  (iBranchTaken),
        .iTarget       (iTarget),
        .iOffset       (iOffset),
        .oIP           (oIP),
        .oRasEmpty     (oRasEmpty),
        .oRasFull      (oRasFull),
        .oRasOverflow  (oRasOverflow),
        .oRasUnderflow (oRasUnderflow)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic modelReset();
        mIp = 0;
        ras.delete();
        expOvf = 0;
        expUnf = 0;
    endtask

    // Behavioural reference: plain modular arithmetic on an int and a bounded queue.
    task automatic modelStep(input bit s, j, c, r, b, input int tgt, input logic [OW-1:0] off);
        int mag;
        expOvf = 0;
        expUnf = 0;
        if (s) return;
        if (r) begin
            if (ras.size() > 0) begin
                mIp = ras.pop_back();
            end else begin
                mIp = (mIp + 1) % MOD;
                expUnf = 1;
            end
        end else if (c) begin
            ras.push_back((mIp + 1) % MOD);
            if (ras.size() > DEPTH) begin
                void'(ras.pop_front());
                expOvf = 1;
            end
            mIp = tgt % MOD;
        end else if (j) begin
            mIp = tgt % MOD;
        end else if (b) begin
            mag = int'(off[OW-2:0]);
            if (off[OW-1]) mIp = (mIp - mag + MOD) % MOD;
            else           mIp = (mIp + mag) % MOD;
        end else begin
            mIp = (mIp + 1) % MOD;
        end
    endtask

    task automatic clearInputs();
        iStall = 0; iJump = 0; iCall = 0; iReturn = 0; iBranchTaken = 0;
        iTarget = '0; iOffset = '0;
    endtask

    task automatic cycle(input bit s, j, c, r, b, input int tgt, input logic [OW-1:0] off);
        iStall = s; iJump = j; iCall = c; iReturn = r; iBranchTaken = b;
        iTarget = AW'(tgt);
        iOffset = off;
        @(posedge Clock);
        modelStep(s, j, c, r, b, tgt, off);
        #1;
        clearInputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic jumpTo(input int tgt);
        cycle(0, 1, 0, 0, 0, tgt, '0);
    endtask

    task automatic branchBy(input logic [OW-1:0] off);
        cycle(0, 0, 0, 0, 1, 0, off);
    endtask

    task automatic callTo(input int tgt);
        cycle(0, 0, 1, 0, 0, tgt, '0);
    endtask

    task automatic doReturn();
        cycle(0, 0, 0, 1, 0, 0, '0);
    endtask

    task automatic test_reset();
        clearInputs();
        Reset_n = 0;
        #3;
        checks++; if (oIP !== 10'd0) begin errors++; $display("[TB] FAIL reset_ip got=%0d want=0", oIP); end
        checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%0b want=1", oRasEmpty); end
        checks++; if (oRasFull !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%0b want=0", oRasFull); end
        checks++; if ({oRasOverflow, oRasUnderflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses got=%b want=00", {oRasOverflow, oRasUnderflow}); end
        @(negedge Clock);
        Reset_n = 1;
        modelReset();
        #1;
        checks++; if (oIP !== 10'd0) begin errors++; $display("[TB] FAIL release_ip got=%0d want=0", oIP); end
        for (int k = 1; k <= 5; k++) begin
            idle();
            checks++; if (oIP !== 10'(k)) begin errors++; $display("[TB] FAIL seq_ip got=%0d want=%0d", oIP, k); end
            checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL seq_empty got=%0b want=1", oRasEmpty); end
        end
    endtask

    task automatic test_branch();
        jumpTo(20);
        checks++; if (oIP !== 10'd20) begin errors++; $display("[TB] FAIL jump_20 got=%0d want=20", oIP); end
        branchBy(6'b000111);
        checks++; if (oIP !== 10'd27) begin errors++; $display("[TB] FAIL branch_fwd got=%0d want=27", oIP); end
        branchBy(6'b101010);
        checks++; if (oIP !== 10'd17) begin errors++; $display("[TB] FAIL branch_back got=%0d want=17", oIP); end
        jumpTo(3);
        branchBy(6'b100101);
        checks++; if (oIP !== 10'd1022) begin errors++; $display("[TB] FAIL branch_wrap_low got=%0d want=1022", oIP); end
        branchBy(6'b100000);
        checks++; if (oIP !== 10'd1022) begin errors++; $display("[TB] FAIL branch_minus_zero got=%0d want=1022", oIP); end
        idle();
        checks++; if (oIP !== 10'd1023) begin errors++; $display("[TB] FAIL inc_1023 got=%0d want=1023", oIP); end
        idle();
        checks++; if (oIP !== 10'd0) begin errors++; $display("[TB] FAIL inc_wrap got=%0d want=0", oIP); end
        branchBy(6'b011111);
        checks++; if (oIP !== 10'd31) begin errors++; $display("[TB] FAIL branch_max got=%0d want=31", oIP); end
    endtask

    task automatic test_call_return();
        jumpTo(100);
        callTo(500);
        checks++; if (oIP !== 10'd500) begin errors++; $display("[TB] FAIL call_ip got=%0d want=500", oIP); end
        checks++; if (oRasEmpty !== 1'b0) begin errors++; $display("[TB] FAIL call_empty got=%0b want=0", oRasEmpty); end
        doReturn();
        checks++; if (oIP !== 10'd101) begin errors++; $display("[TB] FAIL ret_ip got=%0d want=101", oIP); end
        checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL ret_empty got=%0b want=1", oRasEmpty); end
        checks++; if (oRasUnderflow !== 1'b0) begin errors++; $display("[TB] FAIL ret_unf got=%0b want=0", oRasUnderflow); end
        jumpTo(1023);
        callTo(5);
        doReturn();
        checks++; if (oIP !== 10'd0) begin errors++; $display("[TB] FAIL ret_wrap got=%0d want=0", oIP); end
    endtask

    task automatic test_overflow_underflow();
        int callTargets[5] = '{20, 30, 40, 50, 60};
        int retWant[4] = '{51, 41, 31, 21};
        jumpTo(10);
        for (int k = 0; k < 5; k++) begin
            callTo(callTargets[k]);
            checks++; if (oRasOverflow !== (k == 4)) begin errors++; $display("[TB] FAIL ovf_pulse call=%0d got=%0b want=%0b", k, oRasOverflow, (k == 4)); end
            if (k == 3) begin
                checks++; if (oRasFull !== 1'b1) begin errors++; $display("[TB] FAIL full_after4 got=%0b want=1", oRasFull); end
            end
        end
        checks++; if (oRasFull !== 1'b1) begin errors++; $display("[TB] FAIL full_after5 got=%0b want=1", oRasFull); end
        for (int k = 0; k < 4; k++) begin
            doReturn();
            checks++; if (oIP !== 10'(retWant[k])) begin errors++; $display("[TB] FAIL nested_ret got=%0d want=%0d", oIP, retWant[k]); end
            checks++; if (oRasOverflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared got=%0b want=0", oRasOverflow); end
        end
        doReturn();
        checks++; if (oIP !== 10'd22) begin errors++; $display("[TB] FAIL underflow_ip got=%0d want=22", oIP); end
        checks++; if (oRasUnderflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_pulse got=%0b want=1", oRasUnderflow); end
        idle();
        checks++; if (oRasUnderflow !== 1'b0) begin errors++; $display("[TB] FAIL underflow_clear got=%0b want=0", oRasUnderflow); end
        checks++; if (oIP !== 10'd23) begin errors++; $display("[TB] FAIL after_unf_ip got=%0d want=23", oIP); end
    endtask

    task automatic test_stall();
        jumpTo(40);
        callTo(7);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0, 0, 300, '0);
            checks++; if (oIP !== 10'd7) begin errors++; $display("[TB] FAIL stall_ip got=%0d want=7", oIP); end
            checks++; if (oRasEmpty !== 1'b0) begin errors++; $display("[TB] FAIL stall_ras got=%0b want=0", oRasEmpty); end
        end
        idle();
        checks++; if (oIP !== 10'd8) begin errors++; $display("[TB] FAIL stall_release got=%0d want=8", oIP); end
        doReturn();
        checks++; if (oIP !== 10'd41) begin errors++; $display("[TB] FAIL stall_ras_kept got=%0d want=41", oIP); end
        cycle(1, 0, 0, 1, 0, 0, '0);
        checks++; if (oRasUnderflow !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_unf got=%0b want=0", oRasUnderflow); end
        checks++; if (oIP !== 10'd41) begin errors++; $display("[TB] FAIL stall_ret_ip got=%0d want=41", oIP); end
        cycle(1, 0, 1, 0, 0, 9, '0);
        checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL stall_no_push got=%0b want=1", oRasEmpty); end
    endtask

    task automatic test_priority_and_reset();
        jumpTo(63);
        callTo(200);
        cycle(0, 1, 1, 1, 1, 300, 6'b000011);
        checks++; if (oIP !== 10'd64) begin errors++; $display("[TB] FAIL prio_ip got=%0d want=64", oIP); end
        checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL prio_no_push got=%0b want=1", oRasEmpty); end
        cycle(0, 1, 0, 0, 1, 300, 6'b000011);
        checks++; if (oIP !== 10'd300) begin errors++; $display("[TB] FAIL jump_over_branch got=%0d want=300", oIP); end
        callTo(150);
        callTo(250);
        #2;
        Reset_n = 0;
        #1;
        checks++; if (oIP !== 10'd0) begin errors++; $display("[TB] FAIL async_reset_ip got=%0d want=0", oIP); end
        checks++; if (oRasEmpty !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_empty got=%0b want=1", oRasEmpty); end
        @(negedge Clock);
        Reset_n = 1;
        modelReset();
        idle();
        checks++; if ({oRasOverflow, oRasUnderflow} !== 2'b00) begin errors++; $display("[TB] FAIL release_pulses got=%b want=00", {oRasOverflow, oRasUnderflow}); end
        checks++; if (oIP !== 10'd1) begin errors++; $display("[TB] FAIL release_inc got=%0d want=1", oIP); end
        doReturn();
        checks++; if (oRasUnderflow !== 1'b1) begin errors++; $display("[TB] FAIL ras_discarded got=%0b want=1", oRasUnderflow); end
        checks++; if (oIP !== 10'd2) begin errors++; $display("[TB] FAIL ras_discarded_ip got=%0d want=2", oIP); end
    endtask

    task automatic test_random();
        bit s, j, c, r, b;
        int tgt;
        logic [OW-1:0] off;
        Reset_n = 0;
        #1;
        Reset_n = 1;
        modelReset();
        for (int n = 0; n < 400; n++) begin
            s   = ($urandom_range(7) == 0);
            r   = ($urandom_range(3) == 0);
            c   = ($urandom_range(2) == 0);
            j   = ($urandom_range(3) == 0);
            b   = ($urandom_range(2) == 0);
            tgt = int'($urandom_range(MOD - 1));
            off = OW'($urandom);
            cycle(s, j, c, r, b, tgt, off);
            checks++; if (oIP !== AW'(mIp)) begin errors++; $display("[TB] FAIL rand_ip n=%0d got=%0d want=%0d", n, oIP, mIp); end
            checks++; if (oRasEmpty !== (ras.size() == 0)) begin errors++; $display("[TB] FAIL rand_empty n=%0d got=%0b want=%0b", n, oRasEmpty, (ras.size() == 0)); end
            checks++; if (oRasFull !== (ras.size() == DEPTH)) begin errors++; $display("[TB] FAIL rand_full n=%0d got=%0b want=%0b", n, oRasFull, (ras.size() == DEPTH)); end
            checks++; if (oRasOverflow !== expOvf) begin errors++; $display("[TB] FAIL rand_ovf n=%0d got=%0b want=%0b", n, oRasOverflow, expOvf); end
            checks++; if (oRasUnderflow !== expUnf) begin errors++; $display("[TB] FAIL rand_unf n=%0d got=%0b want=%0b", n, oRasUnderflow, expUnf); end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_return();
        test_overflow_underflow();
        test_stall();
        test_priority_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
